// File: rtl/l2_cache_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache with tree
// pseudo-LRU replacement and saturating hit/miss counters.
// Optional macro L2_WRITE_NO_FILL_EN: a write miss installs the requester's
// full line directly instead of filling it from memory first.
module l2_cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int LA_W  = ADDR_W - OFF_W;
  localparam int TAG_W = LA_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITEBACK, FILL} state_t;
  state_t state_q, state_d;

  logic [LA_W-1:0]             line_q, line_d;
  logic [LINE_W-1:0]           wdata_q, wdata_d;
  logic                        write_q, write_d;
  logic                        first_q, first_d;
  logic [WAY_W-1:0]            victim_q, victim_d;
  logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-2:0]   plru_q, plru_d;
  logic [CNT_W-1:0]            hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];

  logic              arr_we;
  logic [WAY_W-1:0]  arr_way;
  logic [LINE_W-1:0] arr_data;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_data [WAYS];
  logic [WAYS-1:0]   way_hit;
  logic              hit, found, victim_dirty, b;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_way, victim_sel, node;
  logic              unused_off;

  assign req_idx    = line_q[IDX_W-1:0];
  assign req_tag    = line_q[LA_W-1 -: TAG_W];
  assign unused_off = ^mem_address[OFF_W-1:0];
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Mark the accessed way as most recent: every node on its path points away.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  res;
    logic [WAY_W-1:0] nd, sh;
    logic             dir;
    res = bits;
    nd  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      sh      = way >> (WAY_W - 1 - l);
      dir     = sh[0];
      res[nd] = ~dir;
      nd      = (nd << 1) + WAY_W'(1) + WAY_W'(dir);
    end
    return res;
  endfunction

  // Per-way tag compare against the captured request.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_tag[gi]  = tag_mem[gi][req_idx];
    assign way_data[gi] = data_mem[gi][req_idx];
    assign way_hit[gi]  = valid_q[req_idx][gi] && (way_tag[gi] == req_tag);
  end

  // Hit way, lowest invalid way and PLRU victim for the addressed set.
  always_comb begin
    hit     = |way_hit;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (way_hit[w]) hit_way = WAY_W'(w);
    found   = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        inv_way = WAY_W'(w);
        found   = 1'b1;
      end
    end
    plru_way = '0;
    node     = '0;
    b        = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      b        = plru_q[req_idx][node];
      plru_way = (plru_way << 1) | WAY_W'(b);
      node     = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
    victim_sel   = found ? inv_way : plru_way;
    victim_dirty = valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (mem_read || mem_write) state_d = TAG_CHECK;
      TAG_CHECK: begin
        if (hit)               state_d = IDLE;
        else if (victim_dirty) state_d = WRITEBACK;
`ifdef L2_WRITE_NO_FILL_EN
        else if (write_q)      state_d = IDLE;
`endif
        else                   state_d = FILL;
      end
      WRITEBACK: begin
        if (pmem_resp) begin
`ifdef L2_WRITE_NO_FILL_EN
          state_d = write_q ? IDLE : FILL;
`else
          state_d = FILL;
`endif
        end
      end
      FILL:      if (pmem_resp) state_d = TAG_CHECK;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs and tag/data array write control.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = way_data[hit_way];
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {line_q, {OFF_W{1'b0}}};
    pmem_wdata   = way_data[victim_q];
    arr_we       = 1'b0;
    arr_way      = hit_way;
    arr_data     = wdata_q;
    case (state_q)
      TAG_CHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          arr_we   = write_q;
        end
`ifdef L2_WRITE_NO_FILL_EN
        else if (write_q && !victim_dirty) begin
          mem_resp = 1'b1;
          arr_we   = 1'b1;
          arr_way  = victim_sel;
        end
`endif
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], req_idx, {OFF_W{1'b0}}};
`ifdef L2_WRITE_NO_FILL_EN
        if (pmem_resp && write_q) begin
          mem_resp = 1'b1;
          arr_we   = 1'b1;
          arr_way  = victim_q;
        end
`endif
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          arr_we   = 1'b1;
          arr_way  = victim_q;
          arr_data = pmem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Request capture, valid/dirty/PLRU bookkeeping and counters.
  always_comb begin
    line_d       = line_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    first_d      = first_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          line_d  = mem_address[ADDR_W-1:OFF_W];
          wdata_d = mem_wdata;
          write_d = mem_write;
          first_d = 1'b1;
        end
      end
      TAG_CHECK: begin
        first_d = 1'b0;
        if (hit) begin
          plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
          if (write_q) dirty_d[req_idx][hit_way] = 1'b1;
          if (first_q && hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
        end else begin
          victim_d = victim_sel;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
`ifdef L2_WRITE_NO_FILL_EN
          if (write_q && !victim_dirty) begin
            valid_d[req_idx][victim_sel] = 1'b1;
            dirty_d[req_idx][victim_sel] = 1'b1;
            plru_d[req_idx] = plru_touch(plru_q[req_idx], victim_sel);
          end
`endif
        end
      end
      WRITEBACK: begin
`ifdef L2_WRITE_NO_FILL_EN
        if (pmem_resp && write_q) begin
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b1;
          plru_d[req_idx] = plru_touch(plru_q[req_idx], victim_q);
        end
`endif
      end
      FILL: begin
        if (pmem_resp) begin
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      first_q      <= 1'b0;
      victim_q     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      plru_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      line_q       <= line_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      first_q      <= first_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      plru_q       <= plru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data arrays are not reset; validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[arr_way][req_idx]  <= req_tag;
      data_mem[arr_way][req_idx] <= arr_data;
    end
  end
endmodule

// File: tb/tb_l2_cache_nway.sv
// Testbench for l2_cache_nway: directed scenarios plus random traffic checked
// against a behavioural cache model and a backing-memory model.
module tb_l2_cache_nway;
  localparam int WAYS = 4, SETS = 8, LINE_W = 128, ADDR_W = 16, CNT_W = 5;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [ADDR_W-1:0] mem_address, pmem_address;
  logic [LINE_W-1:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;
  logic [CNT_W-1:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  l2_cache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural cache model.
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  int                m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  bit                m_tree  [SETS][WAYS-1];
  int                m_hits, m_misses;
  logic [LINE_W-1:0] backing [int];

  // Expectations of the current request and observations from the bus.
  bit                e_hit, e_wb, e_fill;
  logic [ADDR_W-1:0] e_wb_addr, e_fill_addr;
  logic [LINE_W-1:0] e_wb_data, e_rdata;
  bit                last_wb_seen, last_fill_seen;
  logic [ADDR_W-1:0] last_wb_addr, last_fill_addr;
  logic [LINE_W-1:0] last_wb_data, last_rdata;
  int                last_cyc;

  function automatic logic [LINE_W-1:0] mem_line(int la);
    if (!backing.exists(la)) backing[la] = {$urandom, $urandom, $urandom, $urandom};
    return backing[la];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  // Walk the tree by halving the way range; a 0 bit sends us to the lower half.
  function automatic int m_victim(int s);
    int lo = 0, hi = WAYS, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!m_tree[s][n]) begin hi = mid; n = 2 * n + 1; end
      else begin lo = mid; n = 2 * n + 2; end
    end
    return lo;
  endfunction

  function automatic void m_touch(int s, int w);
    int lo = 0, hi = WAYS, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_tree[s][n] = 1; hi = mid; n = 2 * n + 1; end
      else begin m_tree[s][n] = 0; lo = mid; n = 2 * n + 2; end
    end
  endfunction

  function automatic void model_req(bit wr, logic [ADDR_W-1:0] addr, logic [LINE_W-1:0] wd);
    int la, s, t, hw, v;
    la = int'(addr) / 16;
    s = la % SETS;
    t = la / SETS;
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    e_wb = 0; e_fill = 0; e_wb_addr = '0; e_wb_data = '0; e_fill_addr = '0; e_rdata = '0;
    if (hw >= 0) begin
      e_hit = 1;
      e_rdata = m_data[s][hw];
      if (m_hits < CMAX) m_hits++;
      m_touch(s, hw);
      if (wr) begin m_data[s][hw] = wd; m_dirty[s][hw] = 1; end
    end else begin
      e_hit = 0;
      if (m_misses < CMAX) m_misses++;
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
      if (v < 0) v = m_victim(s);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        e_wb = 1;
        e_wb_addr = ADDR_W'((m_tag[s][v] * SETS + s) * 16);
        e_wb_data = m_data[s][v];
        backing[m_tag[s][v] * SETS + s] = m_data[s][v];
      end
      m_tag[s][v] = t;
      m_valid[s][v] = 1;
      m_touch(s, v);
`ifdef L2_WRITE_NO_FILL_EN
      if (wr) begin
        m_data[s][v] = wd;
        m_dirty[s][v] = 1;
      end else
`endif
      begin
        e_fill = 1;
        e_fill_addr = ADDR_W'(la * 16);
        e_rdata = mem_line(la);
        m_data[s][v] = e_rdata;
        m_dirty[s][v] = 0;
        if (wr) begin m_data[s][v] = wd; m_dirty[s][v] = 1; end
      end
    end
  endfunction

  // One request: called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd);
    int cyc, wait_cnt;
    bit got, both, order_bad;
    model_req(wr, addr, wd);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
    got = 0; both = 0; order_bad = 0; cyc = 0; wait_cnt = -1;
    last_wb_seen = 0; last_fill_seen = 0; last_wb_addr = '0; last_wb_data = '0;
    last_fill_addr = '0; last_rdata = '0; last_cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both = 1;
      if (mem_resp) begin
        got = 1; last_cyc = cyc; last_rdata = mem_rdata;
      end else if (pmem_read || pmem_write) begin
        if (wait_cnt < 0) wait_cnt = $urandom_range(0, 2);
        if (wait_cnt == 0) begin
          if (pmem_write) begin
            last_wb_seen = 1; last_wb_addr = pmem_address; last_wb_data = pmem_wdata;
          end else begin
            if (e_wb && !last_wb_seen) order_bad = 1;
            last_fill_seen = 1; last_fill_addr = pmem_address;
            pmem_rdata = mem_line(int'(pmem_address) / 16);
          end
          pmem_resp = 1'b1;
          wait_cnt = -1;
        end else wait_cnt--;
      end
    end
    pmem_resp = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    $display("req %s addr=%h hit=%0b wb=%0b fill=%0b cycles=%0d", wr ? "WR" : "RD", addr,
             e_hit, last_wb_seen, last_fill_seen, last_cyc);
    checks++;
    if (!got) begin errors++; $display("FAIL resp_timeout addr=%h got no mem_resp, required one", addr); end
    checks++;
    if (both) begin errors++; $display("FAIL pmem_exclusive addr=%h pmem_read and pmem_write both high", addr); end
    if (e_hit) begin
      checks++;
      if (last_cyc !== 1) begin errors++; $display("FAIL hit_latency addr=%h got %0d required 1", addr, last_cyc); end
    end
    checks++;
    if (last_wb_seen !== e_wb) begin errors++; $display("FAIL wb_issue addr=%h got %0b required %0b", addr, last_wb_seen, e_wb); end
    if (e_wb && last_wb_seen) begin
      checks++;
      if (last_wb_addr !== e_wb_addr) begin errors++; $display("FAIL wb_addr got %h required %h", last_wb_addr, e_wb_addr); end
      checks++;
      if (last_wb_data !== e_wb_data) begin errors++; $display("FAIL wb_data got %h required %h", last_wb_data, e_wb_data); end
      checks++;
      if (order_bad) begin errors++; $display("FAIL wb_order addr=%h fill issued before writeback", addr); end
    end
    checks++;
    if (last_fill_seen !== e_fill) begin errors++; $display("FAIL fill_issue addr=%h got %0b required %0b", addr, last_fill_seen, e_fill); end
    if (e_fill && last_fill_seen) begin
      checks++;
      if (last_fill_addr !== e_fill_addr) begin errors++; $display("FAIL fill_addr got %h required %h", last_fill_addr, e_fill_addr); end
    end
    if (rd && !wr) begin
      checks++;
      if (last_rdata !== e_rdata) begin errors++; $display("FAIL rdata addr=%h got %h required %h", addr, last_rdata, e_rdata); end
    end
    @(negedge clk);
    checks++;
    if (hit_count !== CNT_W'(m_hits)) begin errors++; $display("FAIL hit_count got %0d required %0d", hit_count, m_hits); end
    checks++;
    if (miss_count !== CNT_W'(m_misses)) begin errors++; $display("FAIL miss_count got %0d required %0d", miss_count, m_misses); end
  endtask

  task automatic test_reset();
    mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; pmem_resp = 0; pmem_rdata = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got %b required 000", {mem_resp, pmem_read, pmem_write});
    end
    @(negedge clk);
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d required 0/0", hit_count, miss_count);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_read_miss_hit();
    logic [LINE_W-1:0] a5;
    test_reset();
    a5 = {16{8'hA5}};
    backing[16'h1230 / 16] = a5;
    do_req(1, 0, 16'h1230, '0);
    checks++;
    if (last_fill_addr !== 16'h1230 || last_rdata !== a5) begin
      errors++; $display("FAIL first_read got addr=%h data=%h required 1230/a5..", last_fill_addr, last_rdata);
    end
    do_req(1, 0, 16'h1230, '0);
    checks++;
    if (last_cyc !== 1 || last_fill_seen || hit_count !== CNT_W'(1)) begin
      errors++; $display("FAIL second_read got cyc=%0d fill=%0b hits=%0d required 1/0/1", last_cyc, last_fill_seen, hit_count);
    end
  endtask

  task automatic test_eviction();
    test_reset();
    for (int i = 0; i < 4; i++) do_req(1, 0, 16'(16'h0030 + i * 16'h80), '0);
    do_req(1, 0, 16'h0230, '0);
    checks++;
    if (last_wb_seen || last_fill_addr !== 16'h0230) begin
      errors++; $display("FAIL clean_evict got wb=%0b fill=%h required 0/0230", last_wb_seen, last_fill_addr);
    end
    do_req(1, 0, 16'h00B0, '0);
    checks++;
    if (last_fill_seen) begin errors++; $display("FAIL evict_kept got fill=1 for 00b0 required hit"); end
    do_req(1, 0, 16'h0030, '0);
    checks++;
    if (!last_fill_seen) begin errors++; $display("FAIL evict_victim got hit for 0030 required miss"); end
  endtask

  task automatic test_writeback();
    logic [LINE_W-1:0] ones;
    bit done;
    ones = {32{4'h1}};
    test_reset();
    for (int i = 0; i < 4; i++) do_req(1, 0, 16'(16'h0030 + i * 16'h80), '0);
    do_req(0, 1, 16'h00B0, ones);
    done = 0;
    for (int i = 4; i < 12 && !done; i++) begin
      do_req(1, 0, 16'(16'h0030 + i * 16'h80), '0);
      done = last_wb_seen;
    end
    checks++;
    if (!done || last_wb_addr !== 16'h00B0 || last_wb_data !== ones) begin
      errors++; $display("FAIL dirty_evict got wb=%0b addr=%h data=%h required 1/00b0/11..", done, last_wb_addr, last_wb_data);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    test_reset();
    mem_read = 1; mem_address = 16'h1230;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_fill_start got no pmem_read required one"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || miss_count !== '0) begin
      errors++; $display("FAIL mid_fill_reset got pmem_read=%b misses=%0d required 0/0", pmem_read, miss_count);
    end
    mem_read = 0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    do_req(1, 0, 16'h1230, '0);
    checks++;
    if (!last_fill_seen || last_fill_addr !== 16'h1230) begin
      errors++; $display("FAIL after_reset_miss got fill=%0b addr=%h required 1/1230", last_fill_seen, last_fill_addr);
    end
  endtask

  task automatic test_write_miss();
    logic [LINE_W-1:0] d;
    bit done;
    d = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    do_req(0, 1, 16'h4440, d);
    checks++;
`ifdef L2_WRITE_NO_FILL_EN
    if (last_fill_seen) begin errors++; $display("FAIL write_no_fill got pmem_read required none"); end
`else
    if (!last_fill_seen) begin errors++; $display("FAIL write_fill got no pmem_read required one"); end
`endif
    done = 0;
    for (int t = 1; t < 10 && !done; t++) begin
      do_req(1, 0, 16'(t * 128 + 16'h40), '0);
      done = last_wb_seen;
    end
    checks++;
    if (!done || last_wb_addr !== 16'h4440 || last_wb_data !== d) begin
      errors++; $display("FAIL write_miss_evict got wb=%0b addr=%h required 1/4440 with written data", done, last_wb_addr);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    bit rd, wr;
    int op;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      a = ADDR_W'($urandom_range(0, 5) * 128 + $urandom_range(2, 3) * 16 + $urandom_range(0, 15));
      op = $urandom_range(0, 9);
      rd = (op < 6) || (op == 9);
      wr = (op >= 6);
      do_req(rd, wr, a, {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_miss_hit();
    test_eviction();
    test_writeback();
    test_reset_mid_fill();
    test_write_miss();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 cache.
- Integrates the tag/data/valid/dirty arrays, a tree pseudo-LRU and the miss-handling controller.
- Sits between the L1 caches (full-line requests) and physical memory (full-line transfers).
- Next generation of the fixed 2-way L2 datapath: adds configurable associativity and set count, and saturating hit/miss counters.

Parameters:
- WAYS, 4, associativity; power of two, >=2.
- SETS, 8, sets per way; power of two, >=2.
- LINE_W, 128, line width in bits; offset bits OFF_W = log2(LINE_W/8).
- ADDR_W, 16, address width; index = addr[OFF_W+log2(SETS)-1:OFF_W], tag = the remaining upper bits.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  upstream line read request.
- mem_write  in  1  upstream full-line write request.
- mem_address  in  ADDR_W  upstream byte address; offset bits ignored.
- mem_wdata  in  LINE_W  upstream write line.
- mem_rdata  out  LINE_W  read line; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_address  out  ADDR_W  line-aligned memory address; offset bits are 0.
- pmem_wdata  out  LINE_W  writeback line.
- pmem_rdata  in  LINE_W  fill line; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.
- hit_count  out  CNT_W  saturating count of first-lookup hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - mem_resp, pmem_read, pmem_write = 0 immediately.
  - All valid, dirty and PLRU bits cleared; hit_count = miss_count = 0.
  - Tag/data arrays are not reset.
  - Reset mid-WRITEBACK/FILL abandons the pmem transaction; every line is invalid afterwards.
- FSM states: IDLE, TAG_CHECK, WRITEBACK, FILL.
- IDLE:
  - On mem_read|mem_write, capture address, wdata and op, then go to TAG_CHECK.
  - If both mem_read and mem_write are asserted, write wins.
  - Upstream changes are ignored until the FSM returns to IDLE.
  - Requester holds the request until mem_resp and drops it the cycle after.
- TAG_CHECK, hit (valid && tag match in any way):
  - mem_resp=1 this cycle; mem_rdata = hit way data.
  - Write: at the clock edge, data <= wdata and dirty <= 1.
  - PLRU updated to point away from the hit way.
  - Go to IDLE.
  - Hit latency: mem_resp in the 2nd cycle of the request.
- TAG_CHECK, miss:
  - miss_count++.
  - Victim = lowest-index invalid way; if all ways are valid, the PLRU victim.
  - Victim valid && dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim data.
  - Held until pmem_resp, then go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {request tag, index, 0}; held until pmem_resp.
  - On pmem_resp: victim data <= pmem_rdata, tag <= request tag, valid=1, dirty=0; go to TAG_CHECK.
  - The re-check hits and completes the request; this hit is not counted in hit_count.
- hit_count increments only on a hit at the first TAG_CHECK of a request.
- Counters saturate at all-ones.
- pmem_read and pmem_write are never both 1.
- Tree PLRU: WAYS-1 bits per set, node 0 is the root.
  - Bit=0 means the victim is in the lower half.
  - Victim search follows the bits from the root.
  - Access sets each node on the path to point away from the accessed way.

Optional Feature:
- Macro: L2_WRITE_NO_FILL_EN.
- Defined: a write miss skips FILL, because the full line is supplied by the requester.
  - After any WRITEBACK, the victim is installed directly with tag, data = wdata, valid=1, dirty=1.
  - mem_resp is asserted in the cycle the line is installed; PLRU is updated.
  - No pmem_read is issued.
- Undefined: write misses fill from memory, then perform the write hit as normal.

Test Plan:
- Reset, read 0x1230 -> pmem_read with pmem_address=0x1230; return line 0xA5A5...A5 -> mem_resp with mem_rdata=0xA5A5...A5; miss_count=1.
- Read 0x1230 again -> mem_resp in cycle 2, no pmem activity, hit_count=1.
- Read 0x0030, 0x00B0, 0x0130, 0x01B0 (index 3, ways 0-3), then read 0x0230 -> way 0 (0x0030) is evicted; no pmem_write (clean); pmem_read at 0x0230.
- Write 0x00B0 with 0x1111...11 (hit), then reads force eviction of 0x00B0 -> pmem_write at 0x00B0 with data 0x1111...11 before the pmem_read.
- Assert rst mid-FILL -> pmem_read drops the same cycle; a following read of the same address misses again.
- With L2_WRITE_NO_FILL_EN: write miss 0x4440 with data D -> no pmem_read, mem_resp returned; a later eviction writes back D to 0x4440.
